// File: rtl/adv_pkg.sv
// Shared definitions for the character-stream blocks: ASCII constants and the
// transmit FSM state encoding.
package adv_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_CONV,
    TX_PICK,
    TX_SEND,
    TX_TERM
  } tx_state_t;

endpackage

// File: rtl/result_ascii_tx_bin2bcd_iter.sv
// Iterative double-dabble converter: one bit per clock, WIDTH clocks per word.
// o_done marks the cycle whose edge performs the final shift.
module bin2bcd_iter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [WIDTH-1:0]    i_bin,
  output logic                o_busy,
  output logic                o_done,
  output logic [4*DIGITS-1:0] o_bcd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  logic [WIDTH-1:0]       r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_cnt;
  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+WIDTH-1:0] w_shift;

  // Add-3 only touches nibbles 5..9, so the 4-bit sum never wraps.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                           : r_bcd[4*gi +: 4];
    end
  endgenerate

  assign w_shift = {w_adj, r_bin} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_bcd <= w_shift[BCD_W+WIDTH-1:WIDTH];
      r_bin <= w_shift[WIDTH-1:0];
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/result_ascii_tx.sv
// Converts one binary result word to unsigned decimal ASCII (MSB digit first,
// optional terminator) on a valid/stall character stream.
module result_ascii_tx
  import adv_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DIGITS    = 10,
  parameter logic [7:0] TERM      = ASCII_NL,
  parameter bit         SEND_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_result_vld,
  output logic             o_busy,
  output logic [7:0]       o_char,
  output logic             o_vld,
  input  logic             i_stall,
  output logic             o_overrun
);

  localparam int IDX_W = $clog2(DIGITS);

  tx_state_t           r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_vld;
  logic [7:0]          r_char;
  logic                r_overrun;

  logic                w_start;
  logic                w_conv_busy;
  logic                w_conv_done;
  logic                w_accept;
  logic [4*DIGITS-1:0] w_bcd;
  logic [3:0]          w_nib [DIGITS];
  logic [IDX_W-1:0]    w_pick_idx;
  logic [IDX_W-1:0]    w_idx_dec;

  assign w_start   = (r_state == TX_IDLE) && i_result_vld;
  assign w_accept  = r_vld && !i_stall;
  assign w_idx_dec = r_idx - IDX_W'(1);

  bin2bcd_iter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_bin   (i_result),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = w_bcd[4*gi +: 4];
    end
  endgenerate

  // Highest non-zero nibble wins; an all-zero value still sends digit 0.
  always_comb begin
    w_pick_idx = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_nib[d] != 4'd0) w_pick_idx = IDX_W'(d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TX_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_vld     <= 1'b0;
      r_char    <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (i_result_vld && r_busy) r_overrun <= 1'b1;
      case (r_state)
        TX_IDLE: begin
          if (i_result_vld) begin
            r_busy  <= 1'b1;
            r_state <= TX_CONV;
          end
        end
        TX_CONV: begin
          if (w_conv_done) r_state <= TX_PICK;
        end
        TX_PICK: begin
          if (!w_conv_busy) begin
            r_idx   <= w_pick_idx;
            r_char  <= ASCII_ZERO + {4'h0, w_nib[w_pick_idx]};
            r_vld   <= 1'b1;
            r_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (w_accept) begin
            if (r_idx != '0) begin
              r_idx  <= w_idx_dec;
              r_char <= ASCII_ZERO + {4'h0, w_nib[w_idx_dec]};
            end else if (SEND_TERM) begin
              r_char  <= TERM;
              r_state <= TX_TERM;
            end else begin
              r_vld   <= 1'b0;
              r_busy  <= 1'b0;
              r_char  <= 8'h00;
              r_state <= TX_IDLE;
            end
          end
        end
        TX_TERM: begin
          if (w_accept) begin
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_char  <= 8'h00;
            r_state <= TX_IDLE;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_vld     = r_vld;
  assign o_char    = r_char;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Bench for result_ascii_tx: a string-level model ($sformatf of each loaded
// value) feeds a char queue that one negedge process checks every accept against.
`timescale 1ns/1ps
module tb_result_ascii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_result = '0;
  logic        i_result_vld = 1'b0;
  logic        i_stall = 1'b0;
  logic        o_busy;
  logic [7:0]  o_char;
  logic        o_vld;
  logic        o_overrun;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_q[$];
  string       rx_str = "";
  bit          rand_stall = 1'b0;
  bit          hold_vld = 1'b0;
  logic [7:0]  hold_char = '0;
  logic [7:0]  pop_c;

  always #5 clk = ~clk;

  result_ascii_tx #(
    .WIDTH     (32),
    .DIGITS    (10),
    .TERM      (8'h0A),
    .SEND_TERM (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_result     (i_result),
    .i_result_vld (i_result_vld),
    .o_busy       (o_busy),
    .o_char       (o_char),
    .o_vld        (o_vld),
    .i_stall      (i_stall),
    .o_overrun    (o_overrun)
  );

  function automatic string esc(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, esc(act), esc(exp));
    end
  endtask

  // Compare process: inputs change just after posedge, so at negedge we know
  // whether the coming edge accepts o_char.
  always @(negedge clk) begin
    if (!rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_hold_vld", o_vld, 1);
        chk("stall_hold_char", o_char, hold_char);
      end
      if (o_vld && !i_stall) begin
        chk("char_was_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          pop_c = exp_q.pop_front();
          chk("char", o_char, pop_c);
        end
        rx_str = $sformatf("%s%c", rx_str, o_char);
      end
      hold_vld  = o_vld && i_stall;
      hold_char = o_char;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_stall) i_stall = 1'($urandom_range(0, 1));
  end

  // inj: 0 none, 1 stray load 10 edges in, 2 stray load on the final-accept cycle
  task automatic send_word(input logic [31:0] v, input int inj);
    string s;
    int    e;
    int    first;
    int    nvld;
    e = 0;
    while (o_busy && e < 200) begin
      @(posedge clk); #1; e++;
    end
    chk("idle_before_load", o_busy, 0);
    s = $sformatf("%0d\n", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    rx_str = "";
    i_result = v;
    i_result_vld = 1'b1;
    @(posedge clk); #1;
    i_result_vld = 1'b0;
    i_result = '0;
    e = 0; first = -1; nvld = 0;
    while (o_busy && e < 3000) begin
      if (inj == 1 && e == 10) begin
        i_result = 32'd7; i_result_vld = 1'b1;
      end else if (inj == 2 && o_vld && !i_stall && exp_q.size() == 1) begin
        i_result = 32'd7; i_result_vld = 1'b1;
      end else begin
        i_result_vld = 1'b0;
      end
      @(posedge clk); #1; e++;
      if (o_vld) nvld++;
      if (o_vld && first < 0) first = e;
      chk("busy_while_pending", o_busy, exp_q.size() != 0);
    end
    i_result_vld = 1'b0;
    chk("word_done_in_time", e < 3000, 1);
    chk("first_vld_edge", first, 33);
    if (!rand_stall) chk("vld_cycles_no_bubble", nvld, s.len());
    chk("queue_drained", exp_q.size(), 0);
    chk("vld_low_at_end", o_vld, 0);
    $display("TX value=%0d sent=\"%s\" chars=%0d", v, esc(rx_str), rx_str.len());
  endtask

  logic [31:0] edge_vals [7] = '{32'd9, 32'd10, 32'd99, 32'd100,
                                 32'd999999999, 32'd1000000000, 32'd4294967294};

  initial begin
    int e;
    #2 rst = 1'b0;
    #1;
    chk("reset_vld", o_vld, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_char", o_char, 0);
    chk("reset_overrun", o_overrun, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    send_word(32'd0, 0);
    chk_str("value_0", rx_str, "0\n");
    send_word(32'd1234, 0);
    chk_str("value_1234", rx_str, "1234\n");
    send_word(32'hFFFF_FFFF, 0);
    chk_str("value_max", rx_str, "4294967295\n");
    chk("rx_len_max", rx_str.len(), 11);
    chk("overrun_clear_so_far", o_overrun, 0);
    foreach (edge_vals[k]) send_word(edge_vals[k], 0);

    send_word(32'd1234, 1);
    chk_str("overrun_word_intact", rx_str, "1234\n");
    chk("overrun_set", o_overrun, 1);

    rand_stall = 1'b1;
    for (int n = 0; n < 1000; n++) send_word($urandom >> $urandom_range(0, 31), 0);
    rand_stall = 1'b0;
    i_stall = 1'b0;
    chk("overrun_sticky", o_overrun, 1);

    // Reset in the middle of a stalled send.
    exp_q.delete();
    i_stall = 1'b1;
    @(posedge clk); #1;
    i_result = 32'hFFFF_FFFF; i_result_vld = 1'b1;
    @(posedge clk); #1;
    i_result_vld = 1'b0;
    e = 0;
    while (!o_vld && e < 100) begin
      @(posedge clk); #1; e++;
    end
    chk("stalled_vld_seen", o_vld, 1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_vld", o_vld, 0);
    chk("async_reset_busy", o_busy, 0);
    chk("async_reset_char", o_char, 0);
    chk("async_reset_overrun", o_overrun, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    i_stall = 1'b0;
    send_word(32'd5, 0);
    chk_str("after_reset_5", rx_str, "5\n");
    chk("after_reset_overrun", o_overrun, 0);

    // Strobe coincident with the final accept must be dropped.
    send_word(32'd1234, 2);
    chk_str("end_strobe_word", rx_str, "1234\n");
    chk("end_strobe_overrun", o_overrun, 1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      chk("end_strobe_not_loaded", o_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
